// File: rtl/conv_host_pkg.sv
// Shared types and constants for the convolution-engine host memory block.
package conv_host_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] CSEL_L0 = 3'd1;
  localparam logic [2:0] CSEL_L1 = 3'd3;

  localparam int IMG_WORDS = 4096;
  localparam int L1_WORDS  = 1024;

endpackage

// File: rtl/conv_host_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port, no reset.
module conv_host_ram #(
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_host_mem.sv
// Host-side image ROM and layer memories for the convolution engine: load, run, dump.
// Optional write statistics are enabled with the CONV_HOST_STATS_EN macro.
module conv_host_mem
  import conv_host_pkg::*;
#(
  parameter int DW     = 20,
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DW-1:0]     load_data,
  output logic              load_ready,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel,
  output logic              dump_valid,
  output logic [DW-1:0]     dump_data,
  output logic              dump_sel,
  input  logic              dump_ready,
  output logic              done,
`ifdef CONV_HOST_STATS_EN
  output logic [12:0]       stat_l0_wr,
  output logic [10:0]       stat_l1_wr,
  output logic [7:0]        stat_bad_sel,
`endif
  output logic [2:0]        fsm_state
);

  // Dump pointer spans L0 then L1; its top bit doubles as the L1 select.
  localparam int DUMP_AW = IMG_AW + 1;
  localparam logic [DUMP_AW-1:0] DUMP_LAST = DUMP_AW'((1 << IMG_AW) + (1 << L1_AW) - 1);
  localparam logic [IMG_AW-1:0]  LOAD_LAST = '1;

  state_t              state;
  logic [IMG_AW-1:0]   load_ptr;
  logic [DUMP_AW-1:0]  dump_ptr;

  logic                run;
  logic                img_we, l0_we, l1_we;
  logic [IMG_AW-1:0]   l0_raddr;
  logic [L1_AW-1:0]    l1_raddr;
  logic [DW-1:0]       l0_rdata, l1_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      load_ptr   <= '0;
      dump_ptr   <= '0;
      load_ready <= 1'b1;
      ready      <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            load_ptr <= load_ptr + 1'b1;
            if (load_ptr == LOAD_LAST) begin
              state      <= ST_READY;
              load_ready <= 1'b0;
              ready      <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (busy) begin
            state <= ST_RUN;
            ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!busy) begin
            state      <= ST_DUMP;
            dump_ptr   <= '0;
            dump_valid <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (dump_ptr == DUMP_LAST) begin
              state      <= ST_DONE;
              dump_ptr   <= '0;
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_ptr <= dump_ptr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_LOAD;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= ST_LOAD;
          load_ready <= 1'b1;
          ready      <= 1'b0;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;
  assign run       = (state == ST_RUN);
  assign img_we    = (state == ST_LOAD) && load_valid;
  assign l0_we     = run && cwr && (csel == CSEL_L0);
  assign l1_we     = run && cwr && (csel == CSEL_L1);
  assign dump_sel  = dump_ptr[IMG_AW];

  // Each layer RAM has a single read port shared between engine reads and the dump.
  assign l0_raddr = (state == ST_DUMP) ? dump_ptr[IMG_AW-1:0] : caddr_rd;
  assign l1_raddr = (state == ST_DUMP) ? dump_ptr[L1_AW-1:0]  : caddr_rd[L1_AW-1:0];

  conv_host_ram #(.DW(DW), .AW(IMG_AW)) u_img (
    .clk(clk), .we(img_we), .waddr(load_ptr), .wdata(load_data),
    .raddr(iaddr), .rdata(idata)
  );

  conv_host_ram #(.DW(DW), .AW(IMG_AW)) u_l0 (
    .clk(clk), .we(l0_we), .waddr(caddr_wr), .wdata(cdata_wr),
    .raddr(l0_raddr), .rdata(l0_rdata)
  );

  conv_host_ram #(.DW(DW), .AW(L1_AW)) u_l1 (
    .clk(clk), .we(l1_we), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
    .raddr(l1_raddr), .rdata(l1_rdata)
  );

  always_comb begin
    cdata_rd = '0;
    if (run && crd) begin
      if (csel == CSEL_L0)      cdata_rd = l0_rdata;
      else if (csel == CSEL_L1) cdata_rd = l1_rdata;
    end
  end

  assign dump_data = dump_sel ? l1_rdata : l0_rdata;

`ifdef CONV_HOST_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_l0_wr   <= '0;
      stat_l1_wr   <= '0;
      stat_bad_sel <= '0;
    end else if (state == ST_READY && busy) begin
      stat_l0_wr   <= '0;
      stat_l1_wr   <= '0;
      stat_bad_sel <= '0;
    end else if (run && cwr) begin
      if (csel == CSEL_L0)        stat_l0_wr   <= stat_l0_wr + 13'd1;
      else if (csel == CSEL_L1)   stat_l1_wr   <= stat_l1_wr + 11'd1;
      else if (stat_bad_sel != 8'hFF) stat_bad_sel <= stat_bad_sel + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed bench for conv_host_mem: load, handshake, layer access, dump, reset recovery.
module tb_conv_host_mem;
  import conv_host_pkg::*;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          ready;
  logic          busy;
  logic [11:0]   iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [11:0]   caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [11:0]   caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          dump_valid;
  logic [DW-1:0] dump_data;
  logic          dump_sel;
  logic          dump_ready;
  logic          done;
  logic [2:0]    fsm_state;
`ifdef CONV_HOST_STATS_EN
  logic [12:0]   stat_l0_wr;
  logic [10:0]   stat_l1_wr;
  logic [7:0]    stat_bad_sel;
`endif

  conv_host_mem dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_sel(dump_sel),
    .dump_ready(dump_ready), .done(done),
`ifdef CONV_HOST_STATS_EN
    .stat_l0_wr(stat_l0_wr), .stat_l1_wr(stat_l1_wr), .stat_bad_sel(stat_bad_sel),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_l0 [4096];
  logic [DW-1:0] exp_l1 [1024];
  logic [DW:0]   exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [DW-1:0] base, input int n);
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      load_data = base + DW'(i);
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic write_layer(input logic [2:0] sel, input logic [11:0] addr, input logic [DW-1:0] data);
    cwr = 1'b1; csel = sel; caddr_wr = addr; cdata_wr = data;
    step();
    cwr = 1'b0;
    if (sel == 3'd1) exp_l0[addr] = data;
    if (sel == 3'd3) exp_l1[addr[9:0]] = data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, cyc, done_cnt, bad_beats, hold_bad, first_l1;
    logic have_hold;
    logic [DW:0] held, e;

    reset = 1'b1; load_valid = 1'b0; load_data = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
    csel = 3'd0; dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_sel", 32'(dump_sel), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_LOAD));
    reset = 1'b0;

    // Frame 1: pixels 0..4095
    load_frame(20'h0, 4095);
    chk("load_ready_before_last", 32'(load_ready), 32'd1);
    chk("ready_before_last", 32'(ready), 32'd0);
    load_frame(20'h00FFF, 1);
    chk("load_ready_after_last", 32'(load_ready), 32'd0);
    chk("ready_after_last", 32'(ready), 32'd1);
    iaddr = 12'h0A5; #1;
    chk("idata_0a5", 32'(idata), 32'h000A5);
    iaddr = 12'hFFF; #1;
    chk("idata_fff", 32'(idata), 32'h00FFF);

    repeat (10) step();
    chk("ready_held", 32'(ready), 32'd1);
    chk("state_ready", 32'(fsm_state), 32'(ST_READY));
    busy = 1'b1;
    step();
    chk("ready_fall", 32'(ready), 32'd0);
    chk("state_run", 32'(fsm_state), 32'(ST_RUN));

    // Fill both layers; L1 writes carry junk upper address bits.
    for (int a = 0; a < 4096; a++) write_layer(3'd1, 12'(a), 20'h50000 ^ DW'(a));
    for (int a = 0; a < 1024; a++) write_layer(3'd3, 12'(a) | 12'hC00, 20'h80000 | DW'(a));

    write_layer(3'd1, 12'd5, 20'h12345);
    crd = 1'b1; csel = 3'd1; caddr_rd = 12'd5; #1;
    chk("rd_l0_5", 32'(cdata_rd), 32'h12345);
    crd = 1'b0; #1;
    chk("rd_crd0", 32'(cdata_rd), 32'h0);

    cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd5; cdata_wr = 20'h55555;
    crd = 1'b1; caddr_rd = 12'd5; #1;
    chk("rd_during_wr_old", 32'(cdata_rd), 32'h12345);
    step();
    cwr = 1'b0; exp_l0[5] = 20'h55555; #1;
    chk("rd_after_wr_new", 32'(cdata_rd), 32'h55555);
    crd = 1'b0;

    write_layer(3'd3, 12'hFFF, 20'hABCDE);
    crd = 1'b1; csel = 3'd3; caddr_rd = 12'h3FF; #1;
    chk("rd_l1_3ff", 32'(cdata_rd), 32'hABCDE);
    csel = 3'd2; #1;
    chk("rd_bad_sel", 32'(cdata_rd), 32'h0);
    crd = 1'b0;

    write_layer(3'd2, 12'd5, 20'h77777);
    write_layer(3'd2, 12'hFFF, 20'h77777);
    crd = 1'b1; csel = 3'd1; caddr_rd = 12'd5; #1;
    chk("bad_wr_l0_kept", 32'(cdata_rd), 32'h55555);
    csel = 3'd3; caddr_rd = 12'h3FF; #1;
    chk("bad_wr_l1_kept", 32'(cdata_rd), 32'hABCDE);
    crd = 1'b0;
`ifdef CONV_HOST_STATS_EN
    chk("stat_l0", 32'(stat_l0_wr), 32'd4098);
    chk("stat_l1", 32'(stat_l1_wr), 32'd1025);
    chk("stat_bad", 32'(stat_bad_sel), 32'd2);
`endif

    for (int a = 0; a < 4096; a++) exp_q.push_back({1'b0, exp_l0[a]});
    for (int a = 0; a < 1024; a++) exp_q.push_back({1'b1, exp_l1[a]});

    busy = 1'b0;
    step();
    chk("state_dump", 32'(fsm_state), 32'(ST_DUMP));
    chk("dump_valid_on", 32'(dump_valid), 32'd1);

    beats = 0; cyc = 0; done_cnt = 0; bad_beats = 0; hold_bad = 0;
    first_l1 = -1; have_hold = 1'b0; held = '0;
    while (beats < 5120 && cyc < 20000) begin
      dump_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) done_cnt++;
      if (have_hold && ({dump_sel, dump_data} !== held)) hold_bad++;
      have_hold = 1'b0;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        if ({dump_sel, dump_data} !== e) begin
          if (bad_beats == 0) $display("first bad beat %0d got %h want %h", beats, {dump_sel, dump_data}, e);
          bad_beats++;
        end
        if (dump_sel && first_l1 < 0) first_l1 = beats;
        beats++;
      end else if (dump_valid) begin
        held = {dump_sel, dump_data};
        have_hold = 1'b1;
      end
      step();
      cyc++;
    end
    chk("dump_beats", 32'(beats), 32'd5120);
    chk("dump_data_order", 32'(bad_beats), 32'd0);
    chk("dump_hold_stable", 32'(hold_bad), 32'd0);
    chk("dump_sel_flip", 32'(first_l1), 32'd4096);
    chk("done_early", 32'(done_cnt), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("dump_valid_off", 32'(dump_valid), 32'd0);
    dump_ready = 1'b0;
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("back_to_load", 32'(load_ready), 32'd1);

    // Frame 2: writes outside RUN must be dropped; reset during dump.
    cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd7; cdata_wr = 20'h0DEAD;
    step();
    cwr = 1'b0;
    load_frame(20'h40000, 4096);
    iaddr = 12'h0A5; #1;
    chk("f2_idata_0a5", 32'(idata), 32'h400A5);
    busy = 1'b1;
    step();
`ifdef CONV_HOST_STATS_EN
    chk("stat_clear_run", 32'(stat_l0_wr), 32'd0);
`endif
    busy = 1'b0;
    step();
    dump_ready = 1'b1;
    bad_beats = 0;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if ({dump_valid, dump_sel, dump_data} !== {2'b10, exp_l0[b]}) bad_beats++;
      step();
    end
    chk("f2_persist_beats", 32'(bad_beats), 32'd0);
    chk("f2_beat100", 32'(dump_data), 32'(exp_l0[100]));
    reset = 1'b1; #1;
    chk("rst_mid_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_mid_load_ready", 32'(load_ready), 32'd1);
    chk("rst_mid_state", 32'(fsm_state), 32'(ST_LOAD));
    dump_ready = 1'b0;
    step();
    reset = 1'b0;

    // Frame 3: partial load then reset; full reload must start at address 0.
    load_frame(20'h70000, 10);
    reset = 1'b1; #2; reset = 1'b0;
    step();
    load_frame(20'h60000, 4095);
    chk("f3_still_load", 32'(fsm_state), 32'(ST_LOAD));
    load_frame(20'h60FFF, 1);
    chk("f3_ready", 32'(ready), 32'd1);
    iaddr = 12'h000; #1;
    chk("f3_idata_0", 32'(idata), 32'h60000);
    iaddr = 12'h009; #1;
    chk("f3_idata_9", 32'(idata), 32'h60009);
    iaddr = 12'hFFF; #1;
    chk("f3_idata_fff", 32'(idata), 32'h60FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_host_mem.md
# conv_host_mem

Host-side counterpart of the image convolution engine. The block owns the image ROM and the two layer memories that the engine reads and writes:
- L0 holds the convolution output, 4096×20.
- L1 holds the max-pool output, 1024×20.

It loads a 64×64 image from an upstream stream, then starts the engine with the `ready`/`busy` handshake. While the engine runs, the block serves its `iaddr`/`idata` and `csel`/`cwr`/`crd` accesses. When `busy` falls, it streams both layer results out. It sits between the system fabric and the convolution engine.

## Interface
Parameters:
- `DW`, default 20: pixel and layer word width.
- `IMG_AW`, default 12: image / L0 address width (4096 words).
- `L1_AW`, default 10: L1 address width (1024 words).

Ports (clock and reset first):
- `clk`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  image beat valid.
- `load_data`  in  DW  pixel, row-major, address 0 first.
- `load_ready`  out  1  block accepts image beat.
- `ready`  out  1  start request to engine.
- `busy`  in  1  engine running.
- `iaddr`  in  12  engine image read address.
- `idata`  out  DW  image word at `iaddr`.
- `cwr`  in  1  layer write strobe.
- `caddr_wr`  in  12  layer write address.
- `cdata_wr`  in  DW  layer write data.
- `crd`  in  1  layer read strobe.
- `caddr_rd`  in  12  layer read address.
- `cdata_rd`  out  DW  layer read data.
- `csel`  in  3  layer select: 3'd1 = L0, 3'd3 = L1.
- `dump_valid`  out  1  result beat valid.
- `dump_data`  out  DW  result word.
- `dump_sel`  out  1  0 = L0 word, 1 = L1 word.
- `dump_ready`  in  1  downstream accepts result.
- `done`  out  1  one-cycle pulse after the last dump beat.

## Operation
States:
- LOAD → READY → RUN → DUMP → DONE → LOAD.

LOAD:
- `load_ready` = 1.
- Each `load_valid && load_ready` writes `img[load_ptr]` and increments `load_ptr`.
- The handshake on `load_ptr` = 4095 moves the FSM to READY and clears `load_ptr`.

READY:
- `ready` = 1 and is held until `busy` is sampled 1; the FSM then goes to RUN.
- `ready` is never asserted in any other state.

RUN:
- `idata` = `img[iaddr]`, combinational, valid in every state.
- On a clock edge with `cwr` = 1:
  - `csel` = 1 writes `L0[caddr_wr]`.
  - `csel` = 3 writes `L1[caddr_wr[9:0]]`; upper address bits are ignored.
  - Any other `csel` value is dropped.
- `cdata_rd` is combinational:
  - `L0[caddr_rd]` when `crd && csel==1`.
  - `L1[caddr_rd[9:0]]` when `crd && csel==3`.
  - 0 otherwise.
- `busy` sampled 0 moves the FSM to DUMP.
- `cwr`, `crd` and `load_valid` are ignored outside RUN, or outside LOAD for `load_valid`.

DUMP:
- `dump_ptr` walks L0 addresses 0..4095 with `dump_sel` = 0, then L1 addresses 0..1023 with `dump_sel` = 1.
- `dump_data` = memory word at `dump_ptr`, combinational.
- `dump_valid` = 1 throughout DUMP.
- The pointer advances only on `dump_valid && dump_ready`.
- The handshake on L1 address 1023 moves the FSM to DONE.

DONE:
- `done` = 1 for exactly one cycle, then the FSM returns to LOAD.

Memories:
- Not reset; contents persist across frames and across reset.

## Timing
- Reset values:
  - state = LOAD, so `load_ready` = 1.
  - `ready` = 0, `dump_valid` = 0, `dump_sel` = 0, `done` = 0.
  - All pointers = 0.
  - `cdata_rd` = 0 while `crd` = 0.
- `ready` rises the cycle after the 4096th load handshake.
- `ready` falls the cycle after `busy` is first sampled high. With the engine, `busy` rises 1 cycle after `ready`, so `ready` is high for 2 cycles.
- Read latency for `idata` and `cdata_rd` is 0 cycles: data is valid in the same cycle as the address. The engine samples it on the next edge.
- Write latency is 1 edge; a read of the same address in the following cycle returns the new data.
- Simultaneous `cwr` and `crd` on the same address: the read returns the old data during that cycle.
- Dump throughput is 1 word/cycle when `dump_ready` is held high, for 5120 beats total. `done` is asserted the cycle after the last beat.
- `dump_data` and `dump_sel` are held stable while `dump_valid && !dump_ready`.
- Reset mid-operation, in any state: the FSM returns to LOAD immediately and any partial frame is discarded. A new load restarts at address 0.

## Configuration
- `CONV_HOST_STATS_EN`, defined: adds outputs `stat_l0_wr[12:0]`, `stat_l1_wr[10:0]` and `stat_bad_sel[7:0]`.
  - These count accepted L0 writes, accepted L1 writes, and dropped writes in RUN.
  - All three clear on reset and on the READY → RUN transition.
  - `stat_bad_sel` saturates at 255.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package `conv_host_pkg` contains:
  - the state enum;
  - `CSEL_L0` = 3'd1 and `CSEL_L1` = 3'd3;
  - `IMG_WORDS` = 4096 and `L1_WORDS` = 1024.
- Sub-module `conv_host_ram`:
  - parameterised depth and width;
  - one synchronous write port and one asynchronous read port.
  - It is instantiated three times: image, L0, L1.
- Read-address muxing is done in the parent, with no extra read ports:
  - L0: `caddr_rd` in RUN, `dump_ptr` in DUMP.
  - L1: the same selection, on address bits [9:0].

## Test plan
- Load pixel values 0..4095 with `load_valid` held high → `load_ready` drops after beat 4096; `ready` is high the next cycle; `iaddr` = 12'h0A5 returns `idata` = 20'h000A5.
- Hold `ready` with `busy` low for 10 cycles → `ready` stays 1; assert `busy` → `ready` is 0 one cycle later and the FSM is in RUN.
- In RUN:
  - write `csel` = 1, `caddr_wr` = 12'd5, `cdata_wr` = 20'h12345, then read with `crd` = 1 → `cdata_rd` = 20'h12345;
  - `crd` = 0 → `cdata_rd` = 0.
- Write `csel` = 3, `caddr_wr` = 12'hFFF, data 20'hABCDE → the L1 dump beat 1023 carries 20'hABCDE; a `csel` = 2 write leaves the L0 and L1 contents unchanged.
- Drop `busy` and toggle `dump_ready` randomly → exactly 5120 beats in address order, with `dump_sel` flipping at beat 4096 and `done` pulsing once.
- Assert `reset` at dump beat 100 → `dump_valid` = 0 and `load_ready` = 1 immediately; the next frame loads from address 0.
